// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with start-glitch rejection
module uart_rx_oversampled #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            frame_err
);
   localparam int SW = (SB_TICK > 16) ? 5 : 4;
   localparam int NW = $clog2(DBIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] b_q, b_d;
   logic [DBIT-1:0] dout_q, dout_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic            rx_s;
   logic            stop_hit;

   assign rx_s     = sync_q[1];
   assign stop_hit = (state_q == STOP) && s_tick && (s_q == SW'(SB_TICK - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         s_q     <= '0;
         n_q     <= '0;
         b_q     <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   // Start detection is the only transition that ignores s_tick.
   always_comb begin
      state_d = state_q;
      sync_d  = {sync_q[0], rx};
      s_d     = s_q;
      n_d     = n_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == SW'(7)) begin
                  if (!rx_s) begin
                     state_d = DATA;
                     s_d     = '0;
                     n_d     = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == SW'(15)) begin
                  s_d = '0;
                  b_d = {rx_s, b_q[DBIT-1:1]};
                  if (n_q == NW'(DBIT - 1)) state_d = STOP;
                  else                      n_d = n_q + NW'(1);
               end else begin
                  s_d = s_q + SW'(1);
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (stop_hit) state_d = IDLE;
               else          s_d = s_q + SW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done_d = stop_hit;
      dout_d = dout_q;
      ferr_d = ferr_q;
      if (stop_hit) begin
         dout_d = b_q;
         ferr_d = ~rx_s;
      end
   end

   assign rx_done_tick = done_q;
   assign dout         = dout_q;
   assign frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - table, directed and randomized checks of the UART receiver
module tb_uart_rx_oversampled;
   logic       clk = 1'b0;
   logic       reset_n, rx_a, rx_b, s_tick;
   logic       done_a, done_b, ferr_a, ferr_b;
   logic [7:0] dout_a;
   logic [6:0] dout_b;

   always #5 clk = ~clk;

   uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx(rx_a), .s_tick(s_tick),
      .rx_done_tick(done_a), .dout(dout_a), .frame_err(ferr_a));

   uart_rx_oversampled #(.DBIT(7), .SB_TICK(32)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx(rx_b), .s_tick(s_tick),
      .rx_done_tick(done_b), .dout(dout_b), .frame_err(ferr_b));

   typedef struct {
      int         idx;
      logic [8:0] d;
      logic       fe;
   } ev_t;

   typedef struct {
      logic [7:0] data;
      bit         stop_ok;
      logic [7:0] exp_dout;
      bit         exp_fe;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;
   int   cur_idx  = 0;
   logic line[$];
   ev_t  got_a[$], got_b[$], exp_q[$];

   // Each line[] entry is one s_tick period; a pulse is tagged with the period whose tick completed it.
   always @(posedge clk) begin
      ev_t e;
      #1;
      if (done_a) begin
         e.idx = cur_idx; e.d = 9'(dout_a); e.fe = ferr_a;
         got_a.push_back(e);
      end
      if (done_b) begin
         e.idx = cur_idx; e.d = 9'(dout_b); e.fe = ferr_b;
         got_b.push_back(e);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic push_idle(input int n);
      repeat (n) line.push_back(1'b1);
   endtask

   task automatic push_frame(input int data, input int dbit, input int sb, input bit stop_ok);
      repeat (16) line.push_back(1'b0);
      for (int k = 0; k < dbit; k++) repeat (16) line.push_back(data[k]);
      if (stop_ok) begin
         repeat (sb) line.push_back(1'b1);
      end else begin
         repeat (sb - 8) line.push_back(1'b0);
         repeat (8) line.push_back(1'b1);
      end
   endtask

   // Reference: sample points are fixed offsets from the first counted start tick.
   task automatic model(input int dbit, input int sb);
      int         t = 0;
      int         t0, e;
      bit         forced = 0;
      logic [8:0] w;
      ev_t        ev;
      exp_q.delete();
      while (t < line.size()) begin
         if (!forced && line[t]) begin
            t++;
            continue;
         end
         forced = 0;
         t0 = t;
         if (t0 + 7 >= line.size()) break;
         if (line[t0 + 7]) begin
            t = t0 + 8;
            continue;
         end
         e = t0 + 7 + 16 * dbit + sb;
         if (e >= line.size()) break;
         w = '0;
         for (int k = 0; k < dbit; k++) w[k] = line[t0 + 7 + 16 * (k + 1)];
         ev.idx = e; ev.d = w; ev.fe = !line[e];
         exp_q.push_back(ev);
         forced = !line[e];
         t = e + 1;
      end
   endtask

   task automatic apply(input bit sel, input int nper, input int stall_at);
      got_a.delete();
      got_b.delete();
      for (int i = 0; i < nper; i++) begin
         @(negedge clk);
         s_tick = 1'b0;
         if (i == stall_at) repeat (50) @(negedge clk);
         cur_idx = i;
         if (sel) rx_b = line[i];
         else     rx_a = line[i];
         repeat (3) @(negedge clk);
         s_tick = 1'b1;
      end
      @(negedge clk);
      s_tick = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic compare(input string tag, input bit sel);
      ev_t g[$];
      if (sel) g = got_b;
      else     g = got_a;
      chk({tag, " pulses"}, g.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < g.size(); i++) begin
         chk($sformatf("%s ev%0d tick", tag, i), g[i].idx, exp_q[i].idx);
         chk($sformatf("%s ev%0d dout", tag, i), 32'(g[i].d), 32'(exp_q[i].d));
         chk($sformatf("%s ev%0d ferr", tag, i), 32'(g[i].fe), 32'(exp_q[i].fe));
      end
   endtask

   task automatic run(input string tag, input bit sel, input int dbit, input int sb, input int stall_at);
      model(dbit, sb);
      apply(sel, line.size(), stall_at);
      compare(tag, sel);
   endtask

   initial begin
      vec_t vt[6];
      bit   sel;
      int   dbit, sb;

      vt[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
      vt[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
      vt[2] = '{8'h55, 1'b1, 8'h55, 1'b0};
      vt[3] = '{8'h00, 1'b1, 8'h00, 1'b0};
      vt[4] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
      vt[5] = '{8'h81, 1'b1, 8'h81, 1'b0};

      reset_n = 1'b0;
      rx_a    = 1'b1;
      rx_b    = 1'b1;
      s_tick  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset done_a", 32'(done_a), 0);
      chk("reset dout_a", 32'(dout_a), 0);
      chk("reset ferr_a", 32'(ferr_a), 0);
      chk("reset dout_b", 32'(dout_b), 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // 4 idle ticks then a default frame: completion on tick 4 + (8 + 128 + 16) - 1.
      for (int v = 0; v < 6; v++) begin
         line.delete();
         push_idle(4);
         push_frame(vt[v].data, 8, 16, vt[v].stop_ok);
         push_idle(20);
         apply(0, line.size(), -1);
         chk($sformatf("vec%0d pulses", v), got_a.size(), 1);
         if (got_a.size() > 0) begin
            chk($sformatf("vec%0d tick", v), got_a[0].idx, 155);
            chk($sformatf("vec%0d dout", v), 32'(got_a[0].d), 32'(vt[v].exp_dout));
            chk($sformatf("vec%0d ferr", v), 32'(got_a[0].fe), 32'(vt[v].exp_fe));
         end
      end

      line.delete();
      push_idle(4);
      push_frame(8'h00, 8, 16, 1'b1);
      push_frame(8'hFF, 8, 16, 1'b1);
      push_idle(20);
      run("b2b", 0, 8, 16, -1);
      chk("b2b pulse count", got_a.size(), 2);
      if (got_a.size() == 2) begin
         chk("b2b first dout", 32'(got_a[0].d), 32'h00);
         chk("b2b second dout", 32'(got_a[1].d), 32'hFF);
         chk("b2b second tick", got_a[1].idx, 155 + 160);
      end

      line.delete();
      push_idle(4);
      repeat (3) line.push_back(1'b0);
      push_idle(20);
      apply(0, line.size(), -1);
      chk("glitch pulses", got_a.size(), 0);
      chk("glitch dout held", 32'(dout_a), 32'hFF);

      line.delete();
      push_idle(4);
      push_frame(8'hC3, 8, 16, 1'b1);
      push_idle(20);
      apply(0, line.size(), 4 + 16 * 4 + 5);
      chk("stall pulses", got_a.size(), 1);
      if (got_a.size() > 0) begin
         chk("stall tick", got_a[0].idx, 155);
         chk("stall dout", 32'(got_a[0].d), 32'hC3);
      end

      // Abort inside data bit 4, then confirm the receiver restarts cleanly.
      line.delete();
      push_idle(4);
      push_frame(8'h81, 8, 16, 1'b1);
      apply(0, 4 + 16 * 5 + 8, -1);
      chk("midreset pulses", got_a.size(), 0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midreset dout", 32'(dout_a), 0);
      chk("midreset done", 32'(done_a), 0);
      chk("midreset ferr", 32'(ferr_a), 0);
      rx_a = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      line.delete();
      push_idle(4);
      push_frame(8'h81, 8, 16, 1'b1);
      push_idle(20);
      apply(0, line.size(), -1);
      chk("postreset pulses", got_a.size(), 1);
      if (got_a.size() > 0) begin
         chk("postreset dout", 32'(got_a[0].d), 32'h81);
         chk("postreset tick", got_a[0].idx, 155);
      end

      line.delete();
      push_idle(4);
      push_frame(8'h5A, 7, 32, 1'b1);
      push_idle(20);
      apply(1, line.size(), -1);
      chk("p7 pulses", got_b.size(), 1);
      if (got_b.size() > 0) begin
         chk("p7 dout", 32'(got_b[0].d), 32'h5A);
         chk("p7 tick", got_b[0].idx, 4 + 8 + 112 + 32 - 1);
         chk("p7 ferr", 32'(got_b[0].fe), 0);
      end

      for (int w = 0; w < 6; w++) begin
         sel  = (w >= 4);
         dbit = sel ? 7 : 8;
         sb   = sel ? 32 : 16;
         line.delete();
         push_idle($urandom_range(1, 10));
         for (int f = 0; f < 4; f++) begin
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 7)) line.push_back(1'b0);
               push_idle($urandom_range(1, 5));
            end else begin
               push_frame(int'($urandom), dbit, sb, $urandom_range(0, 3) != 0);
               push_idle($urandom_range(0, 6));
            end
         end
         push_idle(20);
         run($sformatf("rand%0d", w), sel, dbit, sb, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Serial UART receiver that sits directly downstream of the baud-rate tick generator (a mod-M counter whose `max_tick` drives `s_tick`). It oversamples the asynchronous `rx` line at 16× the baud rate, detects the start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received word with a one-cycle completion strobe. Its outputs feed the receive FIFO / interface stage.

## Interface
- `DBIT`, default 8: data bits per frame, LSB first; legal range 5–9.
- `SB_TICK`, default 16: `s_tick` count for the stop interval; 16, 24 or 32 give 1, 1.5 or 2 stop bits.
- `clk` in 1: single system clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx` in 1: asynchronous serial input; idles high.
- `s_tick` in 1: one-`clk`-wide enable pulse at 16× the baud rate (e.g. M=163 for 50 MHz / 19200 baud).
- `rx_done_tick` out 1: one-cycle pulse when a frame completes.
- `dout` out DBIT: received word; holds until the next completion.
- `frame_err` out 1: stop bit sampled low on the last completed frame.

## Operation
- `rx` passes through a 2-FF synchronizer (both FFs reset to 1). All FSM logic uses the synchronized value `rx_s`.
- Internal registers:
  - `s_reg`: 4-bit tick counter, or 5-bit when `SB_TICK` > 16.
  - `n_reg`: bit counter, clog2(DBIT) bits.
  - `b_reg`: DBIT-bit shift register.
- FSM states are IDLE, START, DATA, STOP. Reset state is IDLE.
- **IDLE:** when `rx_s`==0, go to START and clear `s_reg`. This transition does not depend on `s_tick`.
- **START:** on each `s_tick`:
  - if `s_reg`==7 and `rx_s`==0, go to DATA and clear `s_reg` and `n_reg` (mid-start confirmed);
  - if `s_reg`==7 and `rx_s`==1, return to IDLE (glitch rejected; no strobe, outputs unchanged);
  - otherwise increment `s_reg`.
- **DATA:** on each `s_tick`:
  - if `s_reg`==15, clear `s_reg` and shift `b_reg` <= {`rx_s`, `b_reg`[DBIT-1:1]}. If `n_reg`==DBIT-1, go to STOP; otherwise increment `n_reg`.
  - otherwise increment `s_reg`.
- **STOP:** on each `s_tick`:
  - if `s_reg`==SB_TICK-1, go to IDLE, load `dout`<=`b_reg` and `frame_err`<=~`rx_s`, and pulse `rx_done_tick`;
  - otherwise increment `s_reg`.
- Without an `s_tick`, no counter, shift or state change occurs, except the IDLE→START transition.
- A framing error still completes the frame: `dout` is updated and `rx_done_tick` pulses.
- After STOP the FSM re-enters IDLE. A low `rx_s` in the very next cycle starts a new frame, so back-to-back frames are supported.
- Reset mid-frame: on `reset_n` low the FSM goes to IDLE immediately and all registers clear. The partial frame is discarded with no strobe.
- Counter wrap: the state transitions always clear `s_reg`, so it never wraps naturally.

## Timing
- Reset values:
  - `rx_done_tick`=0, `dout`=0, `frame_err`=0;
  - `s_reg`=0, `n_reg`=0, `b_reg`=0;
  - synchronizer FFs=1.
- `dout`, `frame_err` and `rx_done_tick` are registered. They update in the same clock: the cycle after the final STOP `s_tick` edge.
- `rx_done_tick` is high for exactly one `clk`.
- Synchronizer latency is 2 clks from `rx` to `rx_s`.
- Frame length from IDLE→START to completion is 8 + 16·DBIT + SB_TICK `s_tick` pulses. For defaults: 8+128+16 = 152 ticks.
- Data bit k is sampled on the (8 + 16·(k+1))-th `s_tick` after START entry, i.e. mid-bit.
- Tolerates up to ±~3% baud mismatch at 16× oversampling with 8 data bits.

## Test plan
- **Nominal frame:** `s_tick` every 4 clks; send 0xA5 at 16 ticks/bit, 1 stop bit → single `rx_done_tick` pulse, `dout`=0xA5, `frame_err`=0, pulse 152 ticks after start detection (+2-clk sync).
- **Back-to-back frames:** 0x00 then 0xFF with no idle gap → two pulses; `dout`=0x00 then 0xFF; `frame_err`=0 both.
- **Glitch rejection:** `rx` low for 3 ticks, then high → FSM returns to IDLE; no pulse; `dout` unchanged.
- **Framing error:** send 0x3C with the stop bit held low → pulse occurs, `dout`=0x3C, `frame_err`=1. The next good frame 0x55 clears `frame_err` to 0.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 4 → `dout`=0, no pulse, FSM in IDLE. After release, a full 0x81 frame is received correctly.
- **Tick gating / parameters:** stall `s_tick` for 50 clks mid-DATA → no state change, and the frame still decodes correctly. Rerun with DBIT=7, SB_TICK=32 on 0x5A&0x7F → `dout`=0x5A, pulse at 8+112+32 ticks.
